// File: rtl/sad_min_tracker_if.sv
// Bus bundle for the SAD minimum tracker: search setup, SAD stream and results.
// The master side drives the search, the slave side is the tracker itself.
interface sad_min_tracker_if #(
    parameter int SAD_W = 32,
    parameter int DIM_W = 32
);
    logic             Start;
    logic [DIM_W-1:0] FrameWidth;
    logic [DIM_W-1:0] FrameHeight;
    logic [DIM_W-1:0] WinWidth;
    logic [DIM_W-1:0] WinHeight;
    logic             SADValid;
    logic [SAD_W-1:0] SAD_in;
    logic             Busy;
    logic             Done;
    logic             Err;
    logic [SAD_W-1:0] MinSAD;
    logic [DIM_W-1:0] BestX;
    logic [DIM_W-1:0] BestY;
    logic [DIM_W-1:0] CurX;
    logic [DIM_W-1:0] CurY;

    modport master (
        output Start, FrameWidth, FrameHeight, WinWidth, WinHeight, SADValid, SAD_in,
        input  Busy, Done, Err, MinSAD, BestX, BestY, CurX, CurY
    );

    modport slave (
        input  Start, FrameWidth, FrameHeight, WinWidth, WinHeight, SADValid, SAD_in,
        output Busy, Done, Err, MinSAD, BestX, BestY, CurX, CurY
    );
endinterface

// File: rtl/sad_min_tracker.sv
// Tracks the minimum SAD over a raster-ordered window search and records where
// it occurred; the first of equal minima is kept.
module sad_min_tracker #(
    parameter int SAD_W = 32,
    parameter int DIM_W = 32
) (
    input  logic                Clk,
    input  logic                Reset,
    sad_min_tracker_if.slave    bus
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    state_t           state_r;
    state_t           next_state_s;

    logic [DIM_W-1:0] lim_x_r;
    logic [DIM_W-1:0] lim_y_r;
    logic [SAD_W-1:0] min_sad_r;
    logic [DIM_W-1:0] best_x_r;
    logic [DIM_W-1:0] best_y_r;
    logic [DIM_W-1:0] cur_x_r;
    logic [DIM_W-1:0] cur_y_r;
    logic             err_r;

    logic             legal_s;
    logic             take_start_s;
    logic             accept_s;
    logic             last_s;
    logic             better_s;
    logic             busy_s;
    logic             done_s;

    // Window must be non-empty and fit inside the frame in both axes.
    assign legal_s = (bus.WinWidth  != {DIM_W{1'b0}}) &&
                     (bus.WinHeight != {DIM_W{1'b0}}) &&
                     (bus.WinWidth  <= bus.FrameWidth) &&
                     (bus.WinHeight <= bus.FrameHeight);

    assign take_start_s = bus.Start && (state_r != ST_RUN);
    assign accept_s     = bus.SADValid && (state_r == ST_RUN);
    assign last_s       = (cur_x_r == lim_x_r) && (cur_y_r == lim_y_r);
    assign better_s     = (bus.SAD_in < min_sad_r);

    // State register.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= next_state_s;
        end
    end

    // Next-state decode.
    always_comb begin
        next_state_s = state_r;
        case (state_r)
            ST_IDLE, ST_DONE: begin
                if (bus.Start) begin
                    if (legal_s) begin
                        next_state_s = ST_RUN;
                    end else begin
                        next_state_s = ST_DONE;
                    end
                end else begin
                    next_state_s = state_r;
                end
            end
            ST_RUN: begin
                if (bus.SADValid && last_s) begin
                    next_state_s = ST_DONE;
                end else begin
                    next_state_s = ST_RUN;
                end
            end
            default: begin
                next_state_s = ST_IDLE;
            end
        endcase
    end

    // Status outputs decoded straight from the state register.
    always_comb begin
        busy_s = 1'b0;
        done_s = 1'b0;
        case (state_r)
            ST_IDLE: begin
                busy_s = 1'b0;
                done_s = 1'b0;
            end
            ST_RUN: begin
                busy_s = 1'b1;
                done_s = 1'b0;
            end
            ST_DONE: begin
                busy_s = 1'b0;
                done_s = 1'b1;
            end
            default: begin
                busy_s = 1'b0;
                done_s = 1'b0;
            end
        endcase
    end

    // Search datapath: dimension latch, running minimum and raster position.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            lim_x_r   <= {DIM_W{1'b0}};
            lim_y_r   <= {DIM_W{1'b0}};
            min_sad_r <= {SAD_W{1'b1}};
            best_x_r  <= {DIM_W{1'b0}};
            best_y_r  <= {DIM_W{1'b0}};
            cur_x_r   <= {DIM_W{1'b0}};
            cur_y_r   <= {DIM_W{1'b0}};
            err_r     <= 1'b0;
        end else if (take_start_s) begin
            // Limits may underflow for illegal sizes; they are never used then.
            lim_x_r <= bus.FrameWidth  - bus.WinWidth;
            lim_y_r <= bus.FrameHeight - bus.WinHeight;
            err_r   <= ~legal_s;
            if (legal_s) begin
                min_sad_r <= {SAD_W{1'b1}};
                best_x_r  <= {DIM_W{1'b0}};
                best_y_r  <= {DIM_W{1'b0}};
                cur_x_r   <= {DIM_W{1'b0}};
                cur_y_r   <= {DIM_W{1'b0}};
            end else begin
                min_sad_r <= min_sad_r;
                best_x_r  <= best_x_r;
                best_y_r  <= best_y_r;
                cur_x_r   <= cur_x_r;
                cur_y_r   <= cur_y_r;
            end
        end else if (accept_s) begin
            if (better_s) begin
                min_sad_r <= bus.SAD_in;
                best_x_r  <= cur_x_r;
                best_y_r  <= cur_y_r;
            end else begin
                min_sad_r <= min_sad_r;
                best_x_r  <= best_x_r;
                best_y_r  <= best_y_r;
            end
            // The final position is held so the results stay attributable.
            if (last_s) begin
                cur_x_r <= cur_x_r;
                cur_y_r <= cur_y_r;
            end else if (cur_x_r == lim_x_r) begin
                cur_x_r <= {DIM_W{1'b0}};
                cur_y_r <= cur_y_r + {{(DIM_W-1){1'b0}}, 1'b1};
            end else begin
                cur_x_r <= cur_x_r + {{(DIM_W-1){1'b0}}, 1'b1};
                cur_y_r <= cur_y_r;
            end
        end else begin
            lim_x_r   <= lim_x_r;
            lim_y_r   <= lim_y_r;
            min_sad_r <= min_sad_r;
            best_x_r  <= best_x_r;
            best_y_r  <= best_y_r;
            cur_x_r   <= cur_x_r;
            cur_y_r   <= cur_y_r;
            err_r     <= err_r;
        end
    end

    assign bus.Busy   = busy_s;
    assign bus.Done   = done_s;
    assign bus.Err    = err_r;
    assign bus.MinSAD = min_sad_r;
    assign bus.BestX  = best_x_r;
    assign bus.BestY  = best_y_r;
    assign bus.CurX   = cur_x_r;
    assign bus.CurY   = cur_y_r;

endmodule

// File: tb/tb_sad_min_tracker.sv
// Directed bench for sad_min_tracker; expected values are worked out by hand
// from the search order and the first-minimum-wins rule.
module tb_sad_min_tracker;

    logic clk;
    logic reset;
    int   errors;
    int   checks;

    sad_min_tracker_if #(.SAD_W(32), .DIM_W(32)) bus ();

    sad_min_tracker #(.SAD_W(32), .DIM_W(32)) dut (
        .Clk   (clk),
        .Reset (reset),
        .bus   (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks = checks + 1;
        if (got !== exp) begin
            errors = errors + 1;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    // Advance one clock and settle just past the edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_start(input logic [31:0] fw, input logic [31:0] fh,
                            input logic [31:0] ww, input logic [31:0] wh);
        bus.FrameWidth  = fw;
        bus.FrameHeight = fh;
        bus.WinWidth    = ww;
        bus.WinHeight   = wh;
        bus.Start       = 1'b1;
        tick();
        bus.Start       = 1'b0;
    endtask

    task automatic send_sad(input logic [31:0] v);
        bus.SADValid = 1'b1;
        bus.SAD_in   = v;
        tick();
        bus.SADValid = 1'b0;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        tick();
        reset = 1'b0;
    endtask

    task automatic check_reset_state(input string tag);
        check({tag, "_busy"}, {63'd0, bus.Busy}, 64'd0);
        check({tag, "_done"}, {63'd0, bus.Done}, 64'd0);
        check({tag, "_err"},  {63'd0, bus.Err},  64'd0);
        check({tag, "_min"},  {32'd0, bus.MinSAD}, 64'h0000_0000_FFFF_FFFF);
        check({tag, "_bx"},   {32'd0, bus.BestX}, 64'd0);
        check({tag, "_by"},   {32'd0, bus.BestY}, 64'd0);
        check({tag, "_cx"},   {32'd0, bus.CurX},  64'd0);
        check({tag, "_cy"},   {32'd0, bus.CurY},  64'd0);
    endtask

    task automatic check_result(input string tag, input logic [31:0] min,
                                input logic [31:0] bx, input logic [31:0] by);
        check({tag, "_min"}, {32'd0, bus.MinSAD}, {32'd0, min});
        check({tag, "_bx"},  {32'd0, bus.BestX},  {32'd0, bx});
        check({tag, "_by"},  {32'd0, bus.BestY},  {32'd0, by});
    endtask

    logic [31:0] sads4x4 [9];

    initial begin
        errors = 0;
        checks = 0;
        reset = 1'b1;
        bus.Start = 1'b0;
        bus.SADValid = 1'b0;
        bus.SAD_in = 32'd0;
        bus.FrameWidth = 32'd0;
        bus.FrameHeight = 32'd0;
        bus.WinWidth = 32'd0;
        bus.WinHeight = 32'd0;
        sads4x4 = '{32'd9, 32'd7, 32'd8, 32'd3, 32'd5, 32'd3, 32'd6, 32'd4, 32'd10};

        tick();
        tick();
        reset = 1'b0;
        check_reset_state("rst");

        // 4x4 frame, 2x2 window: 3x3 grid, minimum 3 first seen at (0,1).
        do_start(32'd4, 32'd4, 32'd2, 32'd2);
        check("g9_busy", {63'd0, bus.Busy}, 64'd1);
        for (int i = 0; i < 9; i++) begin
            bus.SADValid = 1'b1;
            bus.SAD_in   = sads4x4[i];
            tick();
            if (i == 3) begin
                check_result("g9_mid", 32'd3, 32'd0, 32'd1);
                check("g9_mid_cx", {32'd0, bus.CurX}, 64'd1);
                check("g9_mid_cy", {32'd0, bus.CurY}, 64'd1);
            end
            if (i == 7) begin
                check("g9_pre_done", {63'd0, bus.Done}, 64'd0);
            end
        end
        bus.SADValid = 1'b0;
        check("g9_done", {63'd0, bus.Done}, 64'd1);
        check("g9_busy_end", {63'd0, bus.Busy}, 64'd0);
        check_result("g9", 32'd3, 32'd0, 32'd1);
        check("g9_cx", {32'd0, bus.CurX}, 64'd2);
        check("g9_cy", {32'd0, bus.CurY}, 64'd2);

        // SADValid while done must leave everything alone.
        send_sad(32'd0);
        check("dn_ign_done", {63'd0, bus.Done}, 64'd1);
        check_result("dn_ign", 32'd3, 32'd0, 32'd1);
        check("dn_ign_cx", {32'd0, bus.CurX}, 64'd2);

        // 1x1 grid; dimension inputs change after Start and must not matter.
        do_start(32'd2, 32'd2, 32'd2, 32'd2);
        check("g1_busy", {63'd0, bus.Busy}, 64'd1);
        bus.FrameWidth = 32'd10;
        bus.FrameHeight = 32'd10;
        bus.WinWidth = 32'd1;
        bus.WinHeight = 32'd1;
        send_sad(32'h0000_0005);
        check("g1_done", {63'd0, bus.Done}, 64'd1);
        check("g1_busy_end", {63'd0, bus.Busy}, 64'd0);
        check("g1_err", {63'd0, bus.Err}, 64'd0);
        check_result("g1", 32'd5, 32'd0, 32'd0);

        // Window wider than frame is rejected straight into DONE.
        do_reset();
        do_start(32'd2, 32'd2, 32'd3, 32'd2);
        check("il_done", {63'd0, bus.Done}, 64'd1);
        check("il_err", {63'd0, bus.Err}, 64'd1);
        check("il_busy", {63'd0, bus.Busy}, 64'd0);
        check("il_min", {32'd0, bus.MinSAD}, 64'h0000_0000_FFFF_FFFF);
        tick();
        check("il_busy2", {63'd0, bus.Busy}, 64'd0);

        // 3x3 frame, 2x2 window, gapped SADs; tie at (1,1) rejected.
        do_start(32'd3, 32'd3, 32'd2, 32'd2);
        check("gp_err_clr", {63'd0, bus.Err}, 64'd0);
        send_sad(32'hFFFF_FFFF);
        tick();
        check("gp_gap_busy", {63'd0, bus.Busy}, 64'd1);
        check("gp_gap_cx", {32'd0, bus.CurX}, 64'd1);
        send_sad(32'hFFFF_FFFF);
        tick();
        send_sad(32'd2);
        tick();
        send_sad(32'd2);
        check("gp_done", {63'd0, bus.Done}, 64'd1);
        check_result("gp", 32'd2, 32'd0, 32'd1);

        // Start with a simultaneous SADValid: Start wins, SAD is dropped.
        bus.SADValid = 1'b1;
        bus.SAD_in = 32'd1;
        do_start(32'd3, 32'd3, 32'd2, 32'd2);
        bus.SADValid = 1'b0;
        check("ss_busy", {63'd0, bus.Busy}, 64'd1);
        check("ss_min", {32'd0, bus.MinSAD}, 64'h0000_0000_FFFF_FFFF);
        check("ss_cx", {32'd0, bus.CurX}, 64'd0);
        for (int i = 0; i < 4; i++) begin
            send_sad(32'hFFFF_FFFF);
            tick();
        end
        check("ao_done", {63'd0, bus.Done}, 64'd1);
        check_result("ao", 32'hFFFF_FFFF, 32'd0, 32'd0);

        // Reset mid-search, then ignored SAD, then a clean new run.
        do_start(32'd3, 32'd3, 32'd2, 32'd2);
        send_sad(32'd4);
        send_sad(32'd6);
        check("mr_min", {32'd0, bus.MinSAD}, 64'd4);
        do_reset();
        check_reset_state("mr");
        send_sad(32'd1);
        check_reset_state("mr_ign");
        do_start(32'd3, 32'd3, 32'd2, 32'd2);
        send_sad(32'd8);
        send_sad(32'd7);
        // Start during RUN must not restart or re-latch dimensions.
        do_start(32'd4, 32'd4, 32'd1, 32'd1);
        check("rs_busy", {63'd0, bus.Busy}, 64'd1);
        check("rs_cx", {32'd0, bus.CurX}, 64'd0);
        check("rs_cy", {32'd0, bus.CurY}, 64'd1);
        check_result("rs", 32'd7, 32'd1, 32'd0);
        send_sad(32'd9);
        send_sad(32'd1);
        check("nr_done", {63'd0, bus.Done}, 64'd1);
        check_result("nr", 32'd1, 32'd1, 32'd1);

        // Reset takes priority over a concurrent Start.
        reset = 1'b1;
        bus.Start = 1'b1;
        tick();
        reset = 1'b0;
        bus.Start = 1'b0;
        check_reset_state("rp");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
